// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer driving a combinational ALU
//
// Purpose: accepts an 8-bit instruction stream over a valid/ready handshake,
// decodes it, drives the ALU operands, and commits ALU results and flags into
// the accumulator, the status register and an internal register file.
//
// Parameters:
//   NREGS    register-file depth (2..16); register index wraps modulo NREGS
//   ACC_RST  accumulator reset value
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   instr_valid/ready    byte handshake; instr_data = {opcode, index} or immediate
//   alu_op/acc/reg       operands to the ALU (alu_op is NOP outside EXEC)
//   alu_result, alu_*    result and flags returned by the ALU
//   acc                  architectural accumulator
//   status               committed flags {s,p,ov,cy,z}
//   busy                 high whenever the sequencer is not in FETCH
//
// Optional feature (macro CTRL_TRACE_EN): adds retire (one pulse per WB) and
// retire_cnt (16-bit wrapping count of WB cycles).

module alu_sequencer #(
  parameter int          NREGS   = 16,
  parameter logic [7:0]  ACC_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  output logic [3:0] alu_op,
  output logic [7:0] alu_acc,
  output logic [7:0] alu_reg,
  input  logic [7:0] alu_result,
  input  logic       alu_z,
  input  logic       alu_cy,
  input  logic       alu_ov,
  input  logic       alu_p,
  input  logic       alu_s,
  output logic [7:0] acc,
  output logic [4:0] status,
  output logic       busy
`ifdef CTRL_TRACE_EN
  ,
  output logic        retire,
  output logic [15:0] retire_cnt
`endif
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_INC = 4'h9;  // highest ALU opcode
  localparam logic [3:0] OP_LDA = 4'hC;
  localparam logic [3:0] OP_STA = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_IMM   = 2'd3
  } state_t;

  state_t state, next_state;

  logic [3:0]    op_q;
  logic [3:0]    idx_q;
  logic [7:0]    res_q;   // sampled ALU result, or the LDI immediate byte
  logic [4:0]    flg_q;   // sampled ALU flags {s,p,ov,cy,z}
  logic [7:0]    regs [NREGS];
  logic [IW-1:0] ridx;
  logic [7:0]    load_val;
  logic          fire;

  assign fire     = instr_valid && instr_ready;
  assign ridx     = IW'({28'd0, idx_q} % NREGS);
  assign load_val = (op_q == OP_LDA) ? regs[ridx] : res_q;
  assign alu_acc  = acc;
  assign alu_reg  = regs[ridx];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (fire) begin
          if (instr_data[7:4] <= OP_INC)      next_state = S_EXEC;
          else if (instr_data[7:4] == OP_LDI) next_state = S_IMM;
          else                                next_state = S_WB;
        end
      end
      S_EXEC:  next_state = S_WB;
      S_WB:    next_state = S_FETCH;
      S_IMM:   if (fire) next_state = S_WB;
      default: next_state = S_FETCH;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    instr_ready = (state == S_FETCH) || (state == S_IMM);
    busy        = (state != S_FETCH);
    alu_op      = (state == S_EXEC) ? op_q : OP_NOP;
  end

  // Datapath: latch instruction, sample ALU, commit in WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOP;
      idx_q  <= 4'd0;
      res_q  <= 8'd0;
      flg_q  <= 5'd0;
      acc    <= ACC_RST;
      status <= 5'd0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'd0;
    end else begin
      if (state == S_FETCH && fire) begin
        op_q  <= instr_data[7:4];
        idx_q <= instr_data[3:0];
      end
      if (state == S_EXEC) begin
        res_q <= alu_result;
        flg_q <= {alu_s, alu_p, alu_ov, alu_cy, alu_z};
      end
      if (state == S_IMM && fire) res_q <= instr_data;
      if (state == S_WB) begin
        if (op_q <= OP_INC) begin
          acc <= res_q;
          // The ALU only drives carry meaningfully on ADD.
          status <= {flg_q[4:2], (op_q == OP_ADD) ? flg_q[1] : status[1], flg_q[0]};
        end else if (op_q == OP_LDA || op_q == OP_LDI) begin
          acc    <= load_val;
          status <= {load_val[7], ~^load_val, status[2:1], (load_val == 8'd0)};
        end else if (op_q == OP_STA) begin
          regs[ridx] <= acc;
        end
      end
    end
  end

`ifdef CTRL_TRACE_EN
  assign retire = (state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_cnt <= 16'd0;
    else if (retire) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer

module tb_alu_sequencer;

  localparam int NREGS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic [3:0] alu_op;
  logic [7:0] alu_acc;
  logic [7:0] alu_reg;
  logic [7:0] alu_result;
  logic       alu_z, alu_cy, alu_ov, alu_p, alu_s;
  logic [7:0] acc;
  logic [4:0] status;
  logic       busy;
`ifdef CTRL_TRACE_EN
  logic        retire;
  logic [15:0] retire_cnt;
  int          pulse_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_acc;
  logic [4:0] m_st;   // {s,p,ov,cy,z}
  logic [7:0] m_regs [NREGS];

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(NREGS), .ACC_RST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .alu_op(alu_op), .alu_acc(alu_acc), .alu_reg(alu_reg), .alu_result(alu_result),
    .alu_z(alu_z), .alu_cy(alu_cy), .alu_ov(alu_ov), .alu_p(alu_p), .alu_s(alu_s),
    .acc(acc), .status(status), .busy(busy)
`ifdef CTRL_TRACE_EN
    , .retire(retire), .retire_cnt(retire_cnt)
`endif
  );

  // Behavioural ALU: returns {result, s, p, ov, cy, z}. Carry is junk except on ADD.
  function automatic logic [12:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, sa, sb, ri;
    logic [7:0] r;
    logic cy, ov;
    ai = a; bi = b;
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    cy = a[0] ^ b[7];
    ov = 1'b0;
    case (op)
      4'h0: ri = 255 - ai;
      4'h1: ri = ai ^ bi;
      4'h2: ri = ai | bi;
      4'h3: ri = ai & bi;
      4'h4: begin ri = ai - bi; ov = (sa - sb < -128) || (sa - sb > 127); end
      4'h5: begin ri = ai + bi; ov = (sa + sb < -128) || (sa + sb > 127); cy = (ai + bi > 255); end
      4'h6: ri = (ai / 2) + (ai % 2) * 128;
      4'h7: ri = (ai * 2) % 256 + ai / 128;
      4'h8: ri = ai - 1;
      4'h9: ri = ai + 1;
      default: ri = 0;
    endcase
    r = 8'(ri & 255);
    return {r, r[7], ($countones(r) % 2 == 0), ov, cy, (r == 8'd0)};
  endfunction

  always_comb begin
    {alu_result, alu_s, alu_p, alu_ov, alu_cy, alu_z} = alu_fn(alu_op, alu_acc, alu_reg);
  end

`ifdef CTRL_TRACE_EN
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pulse_cnt <= 0;
    else if (retire) pulse_cnt <= pulse_cnt + 1;
  end
`endif

  task automatic model_reset();
    m_acc = 8'h00;
    m_st  = 5'd0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
  endtask

  task automatic model_retire(input logic [7:0] b0, input logic [7:0] b1);
    logic [12:0] o;
    int idx;
    idx = b0[3:0] % NREGS;
    if (b0[7:4] <= 4'h9) begin
      o = alu_fn(b0[7:4], m_acc, m_regs[idx]);
      m_acc = o[12:5];
      m_st  = {o[4:2], (b0[7:4] == 4'h5) ? o[1] : m_st[1], o[0]};
    end else if (b0[7:4] == 4'hC || b0[7:4] == 4'hE) begin
      m_acc = (b0[7:4] == 4'hC) ? m_regs[idx] : b1;
      m_st  = {m_acc[7], ($countones(m_acc) % 2 == 0), m_st[2:1], (m_acc == 8'd0)};
    end else if (b0[7:4] == 4'hD) begin
      m_regs[idx] = m_acc;
    end
  endtask

  // Offers one byte, with random idle gaps, until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ($urandom_range(2) == 0) begin
        instr_valid = 1'b0;
        instr_data  = 8'($urandom);
      end else begin
        instr_valid = 1'b1;
        instr_data  = b;
        if (instr_ready) begin
          @(posedge clk);
          #1 instr_valid = 1'b0;
          return;
        end
      end
    end
    checks++; errors++;
    $display("FAIL send_byte timeout: byte %02h not accepted, required within 40 cycles", b);
  endtask

  // Drives one instruction and checks the per-phase handshake and operand timeline.
  task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1);
    logic [3:0] op;
    op = b0[7:4];
    send_byte(b0);
    if (op <= 4'h9) begin
      @(negedge clk);
      instr_valid = 1'($urandom); instr_data = 8'($urandom);
      checks++;
      if (busy !== 1'b1 || instr_ready !== 1'b0 || alu_op !== op ||
          alu_acc !== m_acc || alu_reg !== m_regs[b0[3:0] % NREGS]) begin
        errors++;
        $display("FAIL exec_phase: busy=%b ready=%b op=%h acc=%02h reg=%02h required 1 0 %h %02h %02h",
                 busy, instr_ready, alu_op, alu_acc, alu_reg, op, m_acc, m_regs[b0[3:0] % NREGS]);
      end
    end else if (op == 4'hE) begin
      @(negedge clk);
      instr_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || instr_ready !== 1'b1 || alu_op !== 4'hF) begin
        errors++;
        $display("FAIL imm_phase: busy=%b ready=%b op=%h required 1 1 f", busy, instr_ready, alu_op);
      end
      send_byte(b1);
    end
    @(negedge clk);
    instr_valid = 1'($urandom); instr_data = 8'($urandom);
    checks++;
    if (busy !== 1'b1 || instr_ready !== 1'b0 || alu_op !== 4'hF) begin
      errors++;
      $display("FAIL wb_phase: busy=%b ready=%b op=%h required 1 0 f", busy, instr_ready, alu_op);
    end
    model_retire(b0, b1);
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_return: busy=%b ready=%b required 0 1", busy, instr_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (acc !== 8'h00 || status !== 5'd0 || instr_ready !== 1'b1 || busy !== 1'b0 || alu_op !== 4'hF) begin
      errors++;
      $display("FAIL reset_state: acc=%02h st=%b ready=%b busy=%b op=%h required 00 00000 1 0 f",
               acc, status, instr_ready, busy, alu_op);
    end
    run_instr(8'hE0, 8'h55);
    run_instr(8'hD3, 8'h00);
    send_byte(8'h53);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if (acc !== 8'h00 || status !== 5'd0 || busy !== 1'b0 || alu_op !== 4'hF) begin
      errors++;
      $display("FAIL reset_mid_exec: acc=%02h st=%b busy=%b op=%h required 00 00000 0 f",
               acc, status, busy, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b required 1", instr_ready);
    end
    run_instr(8'hC3, 8'h00);
    checks++;
    if (acc !== 8'h00 || status !== 5'b01001) begin
      errors++;
      $display("FAIL reset_lda_r3: acc=%02h st=%b required 00 01001", acc, status);
    end
  endtask

  task automatic test_add_flags();
    run_instr(8'hE0, 8'h7F);
    run_instr(8'hD1, 8'h00);
    run_instr(8'hE0, 8'h01);
    run_instr(8'h51, 8'h00);
    checks++;
    if (acc !== 8'h80 || status[4] !== 1'b1 || status[0] !== 1'b0 || status[1] !== 1'b0 ||
        status[3] !== 1'b0 || status !== m_st) begin
      errors++;
      $display("FAIL add_overflow: acc=%02h st=%b required 80 %b", acc, status, m_st);
    end
    run_instr(8'hE0, 8'hFF);
    run_instr(8'h51, 8'h00);
    checks++;
    if (acc !== 8'h7E || status[1] !== 1'b1 || status !== m_st) begin
      errors++;
      $display("FAIL add_carry: acc=%02h st=%b required 7e %b", acc, status, m_st);
    end
  endtask

  task automatic test_sub_dec();
    logic cy_prev;
    run_instr(8'hE0, 8'h01);
    cy_prev = m_st[1];
    run_instr(8'h40, 8'h00);
    run_instr(8'h80, 8'h00);
    checks++;
    if (acc !== 8'h00 || status[0] !== 1'b1 || status[3] !== 1'b1 || status[1] !== cy_prev) begin
      errors++;
      $display("FAIL sub_dec: acc=%02h st=%b required 00 z=1 p=1 cy=%b", acc, status, cy_prev);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_save;
    logic [4:0] s_save;
    run_instr(8'hE0, 8'h5A);
    run_instr(8'hD2, 8'h00);
    run_instr(8'h90, 8'h00);
    run_instr(8'h12, 8'h00);
    checks++;
    if (acc !== 8'h01 || status !== m_st) begin
      errors++;
      $display("FAIL sta_then_xor: acc=%02h st=%b required 01 %b", acc, status, m_st);
    end
    a_save = acc;
    s_save = status;
    run_instr(8'hF7, 8'h00);
    run_instr(8'hA3, 8'h00);
    run_instr(8'hB4, 8'h00);
    checks++;
    if (acc !== a_save || status !== s_save) begin
      errors++;
      $display("FAIL nop_untouched: acc=%02h st=%b required %02h %b", acc, status, a_save, s_save);
    end
  endtask

  task automatic test_hold_low();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      instr_data  = 8'($urandom);
    end
    checks++;
    if (busy !== 1'b0 || instr_ready !== 1'b1 || acc !== m_acc || status !== m_st) begin
      errors++;
      $display("FAIL hold_low: busy=%b ready=%b acc=%02h st=%b required 0 1 %02h %b",
               busy, instr_ready, acc, status, m_acc, m_st);
    end
  endtask

  task automatic test_random();
    logic [7:0] b0, b1;
    for (int i = 0; i < 80; i++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      run_instr(b0, b1);
      checks++;
      if (acc !== m_acc || status !== m_st) begin
        errors++;
        $display("FAIL random_%0d instr %02h/%02h: acc=%02h st=%b required %02h %b",
                 i, b0, b1, acc, status, m_acc, m_st);
      end
    end
  endtask

`ifdef CTRL_TRACE_EN
  task automatic test_trace();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_instr(8'hE0, 8'h33);
    run_instr(8'hD4, 8'h00);
    run_instr(8'h54, 8'h00);
    run_instr(8'hF0, 8'h00);
    run_instr(8'h90, 8'h00);
    checks++;
    if (retire_cnt !== 16'd5 || pulse_cnt !== 5) begin
      errors++;
      $display("FAIL trace_count: cnt=%0d pulses=%0d required 5 5", retire_cnt, pulse_cnt);
    end
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_flags();
    test_sub_dec();
    test_back_to_back();
    test_hold_low();
    test_random();
`ifdef CTRL_TRACE_EN
    test_trace();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
